// File: rtl/bus_src_arbiter_pkg.sv
// +----------------------------------------------------------------------------+
// | bus_src_arbiter_pkg                                                        |
// | Source select codes, FSM states and ring helper for the bus arbiter.       |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

package bus_src_arbiter_pkg;

   localparam int N_SRC = 5;

   localparam logic [2:0] SEL_A = 3'd0;
   localparam logic [2:0] SEL_B = 3'd1;
   localparam logic [2:0] SEL_C = 3'd2;
   localparam logic [2:0] SEL_D = 3'd3;
   localparam logic [2:0] SEL_E = 3'd4;

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } arb_state_e;

   // (base + off) mod N_SRC for base in 0..4 and off in 0..5.
   function automatic logic [2:0] wrap5(input logic [2:0] base, input logic [2:0] off);
      logic [3:0] sum;
      sum = {1'b0, base} + {1'b0, off};
      if (sum >= 4'(N_SRC)) begin
         sum = sum - 4'(N_SRC);
      end
      return sum[2:0];
   endfunction

endpackage

`default_nettype wire

// File: rtl/bus_src_arbiter_rr_pick5.sv
// +----------------------------------------------------------------------------+
// | rr_pick5                                                                   |
// | Combinational round-robin pick over five requesters after last_ptr.        |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

module rr_pick5
   import bus_src_arbiter_pkg::*;
(
   input  logic [N_SRC-1:0] req_i,
   input  logic [2:0]       last_ptr_i,
   output logic [2:0]       pick_o,
   output logic             any_o
);

   logic [2:0] idx;

   // Scan from the farthest offset down so the nearest requester after last_ptr wins.
   always_comb begin
      pick_o = SEL_A;
      any_o  = 1'b0;
      idx    = SEL_A;
      for (int k = N_SRC; k >= 1; k--) begin
         idx = wrap5(last_ptr_i, 3'(k));
         if (req_i[idx]) begin
            pick_o = idx;
            any_o  = 1'b1;
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/bus_src_arbiter.sv
// +----------------------------------------------------------------------------+
// | bus_src_arbiter                                                            |
// | Round-robin 5-source bus arbiter with bounded lock bursts and parking.     |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

module bus_src_arbiter
   import bus_src_arbiter_pkg::*;
#(
   parameter int MAX_HOLD = 4,
   parameter int PARK_SEL = 0
)(
   input  logic             clk,
   input  logic             rst,
   input  logic [N_SRC-1:0] req,
   input  logic [N_SRC-1:0] lock,
   output logic [N_SRC-1:0] gnt,
   output logic [2:0]       mux_sel,
   output logic             bus_valid
);

   localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
   localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);
   localparam logic [2:0]    PARK      = 3'(PARK_SEL);

   arb_state_e       state_q, state_d;
   logic [2:0]       last_ptr_q, last_ptr_d;
   logic [HW-1:0]    hold_cnt_q, hold_cnt_d;
   logic [N_SRC-1:0] gnt_q, gnt_d;
   logic [2:0]       mux_sel_q, mux_sel_d;
   logic             bus_valid_q, bus_valid_d;

   logic [2:0] pick;
   logic       any;
   logic       hold;

   rr_pick5 u_pick (
      .req_i      (req),
      .last_ptr_i (last_ptr_q),
      .pick_o     (pick),
      .any_o      (any)
   );

   // hold_cnt never exceeds HOLD_LAST, so equality is the saturation test.
   assign hold = (state_q == ST_GRANT) && req[last_ptr_q] && lock[last_ptr_q] &&
                 (hold_cnt_q != HOLD_LAST);

   always_comb begin
      state_d     = state_q;
      last_ptr_d  = last_ptr_q;
      hold_cnt_d  = hold_cnt_q;
      gnt_d       = gnt_q;
      mux_sel_d   = mux_sel_q;
      bus_valid_d = bus_valid_q;

      if (hold) begin
         hold_cnt_d = hold_cnt_q + HW'(1);
      end else if (any) begin
         state_d     = ST_GRANT;
         last_ptr_d  = pick;
         hold_cnt_d  = '0;
         gnt_d       = N_SRC'(1) << pick;
         mux_sel_d   = pick;
         bus_valid_d = 1'b1;
      end else begin
         state_d     = ST_IDLE;
         hold_cnt_d  = '0;
         gnt_d       = '0;
         mux_sel_d   = PARK;
         bus_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         last_ptr_q  <= SEL_E;
         hold_cnt_q  <= '0;
         gnt_q       <= '0;
         mux_sel_q   <= PARK;
         bus_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         last_ptr_q  <= last_ptr_d;
         hold_cnt_q  <= hold_cnt_d;
         gnt_q       <= gnt_d;
         mux_sel_q   <= mux_sel_d;
         bus_valid_q <= bus_valid_d;
      end
   end

   assign gnt       = gnt_q;
   assign mux_sel   = mux_sel_q;
   assign bus_valid = bus_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_bus_src_arbiter.sv
// +----------------------------------------------------------------------------+
// | tb_bus_src_arbiter                                                         |
// | Directed self-checking bench for bus_src_arbiter (MAX_HOLD=4, PARK_SEL=0). |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_bus_src_arbiter;

   logic       clk;
   logic       rst;
   logic [4:0] req;
   logic [4:0] lock;
   logic [4:0] gnt;
   logic [2:0] mux_sel;
   logic       bus_valid;

   int n_cmp;
   int n_bad;

   bus_src_arbiter #(.MAX_HOLD(4), .PARK_SEL(0)) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .lock      (lock),
      .gnt       (gnt),
      .mux_sel   (mux_sel),
      .bus_valid (bus_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Invariants: grant one-hot or zero, valid mirrors grant, select in range and matching.
   task automatic tick();
      logic [2:0] idx;
      @(posedge clk);
      #1;
      idx = 3'd0;
      for (int i = 0; i < 5; i++) if (gnt[i]) idx = 3'(i);
      check("onehot0", 32'($onehot0(gnt)), 32'd1);
      check("valid_eq_gnt", 32'(bus_valid), 32'(|gnt));
      check("sel_range", 32'(mux_sel <= 3'd4), 32'd1);
      if (bus_valid) check("sel_matches_gnt", 32'(mux_sel), 32'(idx));
   endtask

   task automatic expect_out(input string tag, input logic [4:0] eg, input logic [2:0] es,
                             input logic ev);
      check({tag, "_gnt"}, 32'(gnt), 32'(eg));
      check({tag, "_sel"}, 32'(mux_sel), 32'(es));
      check({tag, "_valid"}, 32'(bus_valid), 32'(ev));
   endtask

   task automatic do_reset();
      rst = 1'b0;
      tick();
      rst = 1'b1;
   endtask

   logic [2:0] seq3 [10];

   initial begin
      n_cmp = 0;
      n_bad = 0;

      // 1: reset with everything requesting, then source 0 wins first
      rst  = 1'b0;
      req  = 5'b11111;
      lock = 5'b11111;
      tick();
      expect_out("t1_rst_a", 5'b00000, 3'd0, 1'b0);
      tick();
      expect_out("t1_rst_b", 5'b00000, 3'd0, 1'b0);
      rst = 1'b1;
      tick();
      expect_out("t1_first", 5'b00001, 3'd0, 1'b1);

      // 2: alternating 0/2 without lock
      req  = 5'b00101;
      lock = 5'b00000;
      do_reset();
      for (int i = 0; i < 4; i++) begin
         tick();
         if (i % 2 == 0) expect_out("t2_alt", 5'b00001, 3'd0, 1'b1);
         else            expect_out("t2_alt", 5'b00100, 3'd2, 1'b1);
      end

      // 3: locked source 4 bursts MAX_HOLD cycles, source 0 squeezes in between
      req  = 5'b10001;
      lock = 5'b10000;
      do_reset();
      seq3 = '{3'd0, 3'd4, 3'd4, 3'd4, 3'd4, 3'd0, 3'd4, 3'd4, 3'd4, 3'd4};
      for (int i = 0; i < 10; i++) begin
         tick();
         expect_out("t3_burst", 5'b00001 << seq3[i], seq3[i], 1'b1);
      end

      // 4: locked owner drops request -> park, then regrant on return
      req  = 5'b00100;
      lock = 5'b00100;
      do_reset();
      tick();
      expect_out("t4_g1", 5'b00100, 3'd2, 1'b1);
      tick();
      expect_out("t4_g2", 5'b00100, 3'd2, 1'b1);
      req = 5'b00000;
      tick();
      expect_out("t4_drop", 5'b00000, 3'd0, 1'b0);
      tick();
      expect_out("t4_idle", 5'b00000, 3'd0, 1'b0);
      req = 5'b00100;
      tick();
      expect_out("t4_regrant", 5'b00100, 3'd2, 1'b1);

      // 5: reset mid-burst clears everything and restores last_ptr
      req  = 5'b01000;
      lock = 5'b01000;
      do_reset();
      tick();
      tick();
      tick();
      check("t5_hold_cnt", 32'(dut.hold_cnt_q), 32'd2);
      expect_out("t5_burst", 5'b01000, 3'd3, 1'b1);
      rst = 1'b0;
      tick();
      expect_out("t5_rst", 5'b00000, 3'd0, 1'b0);
      rst  = 1'b1;
      req  = 5'b01001;
      lock = 5'b00000;
      tick();
      expect_out("t5_first", 5'b00001, 3'd0, 1'b1);
      tick();
      expect_out("t5_next", 5'b01000, 3'd3, 1'b1);

      // 6: lone requester without lock is regranted every cycle
      req  = 5'b01000;
      lock = 5'b00000;
      do_reset();
      for (int i = 0; i < 6; i++) begin
         tick();
         expect_out("t6_solo", 5'b01000, 3'd3, 1'b1);
         check("t6_hold_cnt", 32'(dut.hold_cnt_q), 32'd0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

`default_nettype wire
